// File: rtl/pipe_ctrl_n_if.sv
// Handshake and payload bundle for the N-stage valid/allow-in pipeline controller.
// The master side is the datapath that feeds payloads; the slave side is the controller.
interface pipe_ctrl_if #(
   parameter int STAGES = 3,
   parameter int W      = 64,
   parameter int CNT_W  = 32
);
   logic                  in_valid;
   logic                  in_allowin;
   logic [STAGES*W-1:0]   stage_din;
   logic [STAGES-1:0]     stage_ready_go;
   logic [STAGES-1:0]     flush;
   logic                  out_allow;
   logic [STAGES-1:0]     stage_valid;
   logic [STAGES*W-1:0]   stage_dout;
   logic [STAGES-1:0]     stage_fire;
   logic                  out_valid;
   logic                  drained;
   logic [CNT_W-1:0]      retire_cnt;
   logic [CNT_W-1:0]      stall_cnt;

   modport master (
      output in_valid, stage_din, stage_ready_go, flush, out_allow,
      input  in_allowin, stage_valid, stage_dout, stage_fire, out_valid,
             drained, retire_cnt, stall_cnt
   );

   modport slave (
      input  in_valid, stage_din, stage_ready_go, flush, out_allow,
      output in_allowin, stage_valid, stage_dout, stage_fire, out_valid,
             drained, retire_cnt, stall_cnt
   );
endinterface

// File: rtl/pipe_ctrl_n.sv
// Parametrised N-stage valid/allow-in pipeline controller with payload registers,
// per-stage stall/flush and retire/stall counters.

module pipe_ctrl_stage #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         allowin,
   input  logic         flush,
   input  logic         prev_valid,
   input  logic         fire,
   input  logic [W-1:0] din,
   output logic         valid,
   output logic [W-1:0] dout
);
   // flush always forces allowin, so the flush branch is a dead path kept for readability
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         dout  <= '0;
      end else begin
         if (allowin)    valid <= prev_valid;
         else if (flush) valid <= 1'b0;
         if (fire)       dout  <= din;
      end
   end
endmodule

module pipe_ctrl_n #(
   parameter int STAGES = 3,
   parameter int W      = 64,
   parameter int CNT_W  = 32
) (
   input logic        clk,
   input logic        rst,
   pipe_ctrl_if.slave bus
);
   logic [STAGES-1:0]        vld;
   logic [STAGES-1:0]        to_valid;
   logic [STAGES:0]          allowin;
   logic [STAGES-1:0]        prev_valid;
   logic [STAGES-1:0]        fire;
   logic [STAGES-1:0][W-1:0] dout_q;
   logic [CNT_W-1:0]         retire_q;
   logic [CNT_W-1:0]         stall_q;

   // allowin ripples back from the exit stage; no skid register anywhere in the chain
   always_comb begin
      to_valid        = '0;
      allowin         = '0;
      allowin[STAGES] = bus.out_allow;
      for (int i = STAGES-1; i >= 0; i--) begin
         to_valid[i] = vld[i] & bus.stage_ready_go[i] & ~bus.flush[i];
         allowin[i]  = ~vld[i] | bus.flush[i] | (bus.stage_ready_go[i] & allowin[i+1]);
      end
   end

   assign prev_valid = {to_valid[STAGES-2:0], bus.in_valid};
   assign fire       = prev_valid & allowin[STAGES-1:0];

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      pipe_ctrl_stage #(.W(W)) u_stage (
         .clk        (clk),
         .rst        (rst),
         .allowin    (allowin[i]),
         .flush      (bus.flush[i]),
         .prev_valid (prev_valid[i]),
         .fire       (fire[i]),
         .din        (bus.stage_din[i*W +: W]),
         .valid      (vld[i]),
         .dout       (dout_q[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         retire_q <= '0;
         stall_q  <= '0;
      end else begin
         if (to_valid[STAGES-1] & bus.out_allow) retire_q <= retire_q + CNT_W'(1);
         if (bus.in_valid & ~allowin[0])         stall_q  <= stall_q + CNT_W'(1);
      end
   end

   assign bus.in_allowin  = allowin[0];
   assign bus.stage_valid = vld;
   assign bus.stage_dout  = dout_q;
   assign bus.stage_fire  = fire;
   assign bus.out_valid   = to_valid[STAGES-1];
   assign bus.drained     = ~|vld;
   assign bus.retire_cnt  = retire_q;
   assign bus.stall_cnt   = stall_q;
endmodule

// File: doc/pipe_ctrl_n.md
# pipe_ctrl_n

Parametrised N-stage valid/allow-in pipeline controller with payload registers, per-stage stall (ready_go), per-stage flush and retire/stall counters. It replaces the fixed three-stage ID/IS/WB controller in the npc core. Each stage register loads a fresh payload computed by external datapath logic from the previous stage's output. One generic block now serves the core pipeline and any future 4-/5-stage variants.

## Interface
Parameters:
- STAGES, 3, number of pipeline stages (≥2); stage 0 is the entry stage, stage STAGES-1 is the exit stage.
- W, 64, payload width per stage in bits.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream offers an entry; its payload is stage_din slice 0.
- in_allowin  out  1  stage 0 accepts this cycle (= allowin[0]).
- stage_din  in  STAGES*W  next payload per stage; slice i = bits [i*W +: W].
- stage_ready_go  in  STAGES  stage i has finished its work this cycle.
- flush  in  STAGES  kill the entry currently held in stage i.
- out_allow  in  1  downstream accepts the exit stage's output.
- stage_valid  out  STAGES  valid bit per stage.
- stage_dout  out  STAGES*W  registered payload per stage.
- stage_fire  out  STAGES  stage i loads stage_din slice i at the next edge.
- out_valid  out  1  exit stage hands off this cycle.
- drained  out  1  no stage holds a valid entry.
- retire_cnt  out  CNT_W  number of out_valid & out_allow cycles.
- stall_cnt  out  CNT_W  number of in_valid & ~in_allowin cycles.

## Operation
Define the following, with to_valid[-1] = in_valid and allowin[STAGES] = out_allow:
- to_valid[i] = valid[i] & ready_go[i] & ~flush[i].
- allowin[i] = ~valid[i] | flush[i] | (ready_go[i] & allowin[i+1]).
- stage_fire[i] = to_valid[i-1] & allowin[i].

Valid register update for each stage i:
- if allowin[i]: valid[i] <= to_valid[i-1];
- else if flush[i]: valid[i] <= 0. This branch is unreachable, since flush forces allowin, and is kept for clarity.
- else: hold.

Payload and output rules:
- Payload i loads stage_din slice i only when stage_fire[i]; otherwise it holds, including while invalid.
- out_valid = to_valid[STAGES-1].
- drained = ~|valid.
- A flushed stage reports a free slot in the same cycle. An entry arriving from stage i-1 in that cycle is accepted, unless stage i-1 is itself flushed.
- A stage that holds an entry but has ready_go = 0 blocks itself and, through the allowin chain, every earlier stage.

Counters:
- retire_cnt increments on out_valid & out_allow.
- stall_cnt increments on in_valid & ~in_allowin.
- Both counters wrap modulo 2^CNT_W. Flushed entries are not counted as retired.

Reset behaviour:
- rst has priority over all other inputs.
- All valid bits reset to 0, all payload registers to 0, and both counters to 0.
- A reset asserted mid-operation discards every in-flight entry at that edge.
- In the reset cycle, outputs are computed from the current register state. From the first cycle after reset: in_allowin = 1, out_valid = 0, drained = 1.

## Timing
- All state changes on the posedge of clk.
- allowin, stage_fire, out_valid and in_allowin are combinational from the current state and from ready_go, flush and out_allow. allowin ripples from out_allow back to in_allowin with no registered skid.
- Minimum latency with all ready_go = 1 and out_allow = 1: an entry accepted at edge t is out_valid in the cycle after edge t+STAGES-1, i.e. it occupies each stage for one cycle.
- Throughput is 1 entry/cycle when nothing stalls. A full pipe can retire and accept in the same cycle.
- With out_allow = 0 and a full pipe, in_allowin = 0, and all payloads and valid bits hold.
- flush[i] takes effect at the next edge. The killed entry never reaches stage i+1 and never asserts out_valid.

## Test plan
- Streaming: STAGES=3, 5 entries on consecutive cycles, payload slice i = slice i-1 of stage_dout + 1, all ready_go = 1, out_allow = 1 -> out_valid on 5 consecutive cycles starting 3 cycles after the first accept; exit payload = input + 2; retire_cnt = 5; stall_cnt = 0.
- Back-pressure: fill the pipe, then hold out_allow = 0 for 4 cycles -> in_allowin = 0; stall_cnt +4 while in_valid = 1; payloads unchanged; on release, retire in order with no loss or duplication.
- Mid-stage stall: ready_go[1] = 0 for 2 cycles with a full pipe -> stage 2 drains (valid[2] = 0 after 1 cycle); stages 0 and 1 hold; no bubble is inserted upstream of stage 1.
- Flush: flush = 3'b011 for one cycle while in_valid = 1 with a full pipe -> valid[0] is reloaded with the new entry, valid[1] = 0, and stage 2 retires normally; retire_cnt counts only survivors.
- Reset mid-operation: rst pulse with 3 valid entries -> the next cycle shows stage_valid = 0, drained = 1, retire_cnt = 0, all stage_dout = 0.
- Counter wrap: CNT_W = 4, 17 retires -> retire_cnt = 1.
